// File: rtl/axi_rd_pkg.sv
// Shared encodings for the AXI4 read-channel slave: FSM states, response,
// burst and size codes, output FIFO depth and the per-beat response rule.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [2:0] SIZE_8B = 3'b011;

  localparam int FIFO_DEPTH = 2;

  function automatic logic [1:0] beat_resp(input logic req_err, input logic out_of_range);
    return (req_err || out_of_range) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_rd_fifo2.sv
// Two-entry synchronous FIFO holding {last, resp, data} beats for the R channel;
// push and pop may occur in the same cycle.
module axi_rd_fifo2
  import axi_rd_pkg::*;
#(
  parameter int W = 67
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage carries no reset; only occupancy is control state.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/axi_slave_rd.sv
// AXI4 read-channel slave backed by a 1-cycle-latency RAM, one burst at a time.
// Optional AXI_SLV_RD_ADDR_CHECK_EN: beats at word address >= MEM_DEPTH return SLVERR/zero data.
module axi_slave_rd
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [3:0]        s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              mem_rd_en,
  output logic [ADDR_W-4:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int WA = ADDR_W - 3;
  localparam int PW = DATA_W + 3;

  state_t          state, state_nxt;
  logic [3:0]      id_q;
  logic [WA-1:0]   waddr;
  logic [7:0]      len_q;
  logic [7:0]      beat_cnt;
  logic [1:0]      burst_q;
  logic            err_q;
  logic            issue, pop, oor, last_beat, unused_ok;
  logic [2:0]      occupancy;
  logic            vld_p1, last_p1, oor_p1;
  logic [1:0]      resp_p1;
  logic [1:0]      fifo_cnt;
  logic            fifo_empty;
  logic [PW-1:0]   head;
  logic [DATA_W-1:0] push_data;

  assign pop       = s_axi_rvalid & s_axi_rready;
  // A read in flight already owns a FIFO slot, so it is counted as occupied.
  assign occupancy = {1'b0, fifo_cnt} + {2'b0, vld_p1} - {2'b0, pop};
  assign issue     = (state == ST_BURST) && (occupancy < 3'(FIFO_DEPTH));
  assign last_beat = (beat_cnt == len_q);

`ifdef AXI_SLV_RD_ADDR_CHECK_EN
  assign oor       = (32'(waddr) >= 32'(MEM_DEPTH));
  assign unused_ok = ^s_axi_araddr[2:0];
`else
  assign oor       = 1'b0;
  assign unused_ok = ^{s_axi_araddr[2:0], MEM_DEPTH[0]};
`endif

  assign mem_rd_en   = issue & ~oor;
  assign mem_rd_addr = waddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    s_axi_arready = 1'b0;
    unique case (state)
      ST_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) state_nxt = ST_BURST;
      end
      ST_BURST: if (issue && last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && s_axi_rlast) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= 4'd0;
      waddr    <= '0;
      len_q    <= 8'd0;
      burst_q  <= BURST_FIXED;
      err_q    <= 1'b0;
      beat_cnt <= 8'd0;
    end else if (state == ST_IDLE && s_axi_arvalid) begin
      id_q     <= s_axi_arid;
      waddr    <= s_axi_araddr[ADDR_W-1:3];
      len_q    <= s_axi_arlen;
      burst_q  <= s_axi_arburst;
      err_q    <= (s_axi_arburst == BURST_RSVD) || (s_axi_arsize != SIZE_8B);
      beat_cnt <= 8'd0;
    end else if (issue) begin
      beat_cnt <= beat_cnt + 8'd1;
      if (burst_q != BURST_FIXED) waddr <= waddr + WA'(1);
    end
  end

  // ---- p0 -> p1: RAM access in flight, sideband travels with it ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    last_p1 <= last_beat;
    resp_p1 <= beat_resp(err_q, oor);
    oor_p1  <= oor;
  end

  // ---- p1 -> FIFO: RAM data (zero for an out-of-range beat) joins its sideband ----
  assign push_data = oor_p1 ? '0 : mem_rd_data;

  axi_rd_fifo2 #(.W(PW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_p1),
    .pop   (pop),
    .din   ({last_p1, resp_p1, push_data}),
    .dout  (head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  assign s_axi_rvalid = ~fifo_empty;
  assign s_axi_rdata  = s_axi_rvalid ? head[DATA_W-1:0] : '0;
  assign s_axi_rresp  = s_axi_rvalid ? head[DATA_W+1:DATA_W] : RESP_OKAY;
  assign s_axi_rlast  = s_axi_rvalid & head[DATA_W+2];
  assign s_axi_rid    = id_q;

endmodule
